// File: rtl/qspi_slv_pkg.sv
// qspi_slv_pkg: shared types and constants for the QSPI target.
//   state_t          FSM encodings
//   cmd_t            decoded command byte {read, quad, addr}
//   CMD_*_BIT/MSB    command field positions
//   UNDERRUN_DAT_DEF default byte driven when the host has nothing to send
package qspi_slv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        DUMMY,
        RDATA
    } state_t;

    localparam int unsigned CMD_READ_BIT = 7;
    localparam int unsigned CMD_QUAD_BIT = 6;
    localparam int unsigned CMD_ADDR_MSB = 5;

    localparam logic [7:0] UNDERRUN_DAT_DEF = 8'hFF;

    typedef struct packed {
        logic                  read;
        logic                  quad;
        logic [CMD_ADDR_MSB:0] addr;
    } cmd_t;

    // Split a received command byte into its fields.
    function automatic cmd_t decode_cmd(input logic [7:0] b);
        cmd_t c;
        c.read = b[CMD_READ_BIT];
        c.quad = b[CMD_QUAD_BIT];
        c.addr = b[CMD_ADDR_MSB:0];
        return c;
    endfunction

endpackage

// File: rtl/qspi_slave_if.sv
// qspi_slave_if: QSPI pad bundle between a bus master and the qspi_slave target.
//   qspi_sck, qspi_csn          clock and active-low select from the master
//   qspi_dqN_i                  pad inputs seen by the target
//   qspi_dqN_o / qspi_dqN_en    pad outputs and output enables (1 = drive) from the target
interface qspi_slave_if;

    logic qspi_sck;
    logic qspi_csn;
    logic qspi_dq0_i, qspi_dq1_i, qspi_dq2_i, qspi_dq3_i;
    logic qspi_dq0_o, qspi_dq1_o, qspi_dq2_o, qspi_dq3_o;
    logic qspi_dq0_en, qspi_dq1_en, qspi_dq2_en, qspi_dq3_en;

    modport master (
        output qspi_sck, qspi_csn,
        output qspi_dq0_i, qspi_dq1_i, qspi_dq2_i, qspi_dq3_i,
        input  qspi_dq0_o, qspi_dq1_o, qspi_dq2_o, qspi_dq3_o,
        input  qspi_dq0_en, qspi_dq1_en, qspi_dq2_en, qspi_dq3_en
    );

    modport slave (
        input  qspi_sck, qspi_csn,
        input  qspi_dq0_i, qspi_dq1_i, qspi_dq2_i, qspi_dq3_i,
        output qspi_dq0_o, qspi_dq1_o, qspi_dq2_o, qspi_dq3_o,
        output qspi_dq0_en, qspi_dq1_en, qspi_dq2_en, qspi_dq3_en
    );

endinterface

// File: rtl/qspi_slv_sync.sv
// qspi_slv_sync: brings sck, csn and dq[3:0] into the clk domain and derives edge strobes.
// QSPI_SLV_SYNC_EN defined: two-flop synchronizer per line (asynchronous master).
// QSPI_SLV_SYNC_EN undefined: single capture register (master shares clk).
//   clk, rst_n                  system clock, async active-low reset
//   sck, csn, dq                raw pad inputs
//   dq_lvl                      captured dq, aligned with the sck strobes
//   sck_rise_c/sck_fall_c       one-clk sck edge strobes
//   csn_rise_c/csn_fall_c       one-clk csn edge strobes
module qspi_slv_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       csn,
    input  logic [3:0] dq,
    output logic [3:0] dq_lvl,
    output logic       sck_rise_c,
    output logic       sck_fall_c,
    output logic       csn_rise_c,
    output logic       csn_fall_c
);

    localparam int unsigned W = 6;
    // csn resets to its idle (high) level so reset release is not seen as a select.
    localparam logic [W-1:0] RST_VAL = W'(6'b00_0010);

    logic [W-1:0] pad;
    logic [W-1:0] cap_q;
    logic         sck_prev_q;
    logic         csn_prev_q;

    assign pad = {dq, csn, sck};

`ifdef QSPI_SLV_SYNC_EN
    logic [W-1:0] meta_q;

    // Two-flop synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            cap_q  <= RST_VAL;
        end else begin
            meta_q <= pad;
            cap_q  <= meta_q;
        end
    end
`else
    // Single capture stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cap_q <= RST_VAL;
        else        cap_q <= pad;
    end
`endif

    // Previous captured levels for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_prev_q <= 1'b0;
            csn_prev_q <= 1'b1;
        end else begin
            sck_prev_q <= cap_q[0];
            csn_prev_q <= cap_q[1];
        end
    end

    assign sck_rise_c = cap_q[0] & ~sck_prev_q;
    assign sck_fall_c = ~cap_q[0] & sck_prev_q;
    assign csn_rise_c = cap_q[1] & ~csn_prev_q;
    assign csn_fall_c = ~cap_q[1] & csn_prev_q;
    assign dq_lvl     = cap_q[5:2];

endmodule

// File: rtl/qspi_slave.sv
// qspi_slave: SPI mode-0 QSPI target. Decodes a one-byte single-lane command, then
// receives write bytes (rx_*) or streams read bytes fetched from the host (tx_*).
// Pad capture depth is selected by QSPI_SLV_SYNC_EN (see qspi_slv_sync).
//   clk, rst_n             system clock (>= 8x sck), async active-low reset
//   bus                    QSPI pads (qspi_slave_if.slave)
//   cmd_vld/read/quad/addr command strobe and held fields
//   rx_vld, rx_dat         received write byte, one-cycle strobe, no back-pressure
//   tx_vld, tx_rdy, tx_dat read byte offered by host; tx_rdy pulses on consumption
//   busy                   select active
//   underrun               sticky, set when a read byte was needed but not offered
module qspi_slave
    import qspi_slv_pkg::*;
#(
    parameter int unsigned DUMMY_CYC    = 4,
    parameter logic [7:0]  UNDERRUN_DAT = UNDERRUN_DAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    qspi_slave_if.slave           bus,
    output logic                  cmd_vld,
    output logic                  cmd_read,
    output logic                  cmd_quad,
    output logic [CMD_ADDR_MSB:0] cmd_addr,
    output logic                  rx_vld,
    output logic [7:0]            rx_dat,
    input  logic                  tx_vld,
    output logic                  tx_rdy,
    input  logic [7:0]            tx_dat,
    output logic                  busy,
    output logic                  underrun
);

    logic [3:0] dq_lvl;
    logic       sck_rise_c, sck_fall_c, csn_rise_c, csn_fall_c;

    qspi_slv_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sck        (bus.qspi_sck),
        .csn        (bus.qspi_csn),
        .dq         ({bus.qspi_dq3_i, bus.qspi_dq2_i, bus.qspi_dq1_i, bus.qspi_dq0_i}),
        .dq_lvl     (dq_lvl),
        .sck_rise_c (sck_rise_c),
        .sck_fall_c (sck_fall_c),
        .csn_rise_c (csn_rise_c),
        .csn_fall_c (csn_fall_c)
    );

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] dum_cnt_q, dum_cnt_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    cmd_t       cmd_q, cmd_d;
    logic       cmd_vld_q, cmd_vld_d;
    logic       rx_vld_q, rx_vld_d;
    logic [7:0] rx_dat_q, rx_dat_d;
    logic       tx_rdy_q, tx_rdy_d;
    logic       busy_q, busy_d;
    logic       underrun_q, underrun_d;
    logic [3:0] dq_o_q, dq_o_d;
    logic [3:0] dq_en_q, dq_en_d;

    logic       wide_c;
    logic       byte_done_c;
    logic [2:0] bit_next_c;
    logic [7:0] rx_next_c;
    logic [7:0] tx_src_c;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            dum_cnt_q  <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            cmd_q      <= '0;
            cmd_vld_q  <= 1'b0;
            rx_vld_q   <= 1'b0;
            rx_dat_q   <= '0;
            tx_rdy_q   <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            dq_o_q     <= '0;
            dq_en_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            dum_cnt_q  <= dum_cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            cmd_q      <= cmd_d;
            cmd_vld_q  <= cmd_vld_d;
            rx_vld_q   <= rx_vld_d;
            rx_dat_q   <= rx_dat_d;
            tx_rdy_q   <= tx_rdy_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            dq_o_q     <= dq_o_d;
            dq_en_q    <= dq_en_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        dum_cnt_d  = dum_cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        cmd_d      = cmd_q;
        cmd_vld_d  = 1'b0;
        rx_vld_d   = 1'b0;
        rx_dat_d   = rx_dat_q;
        tx_rdy_d   = 1'b0;
        busy_d     = busy_q;
        underrun_d = underrun_q;
        dq_o_d     = dq_o_q;
        dq_en_d    = dq_en_q;

        // The command phase is always single lane; cmd_q still holds the previous command then.
        wide_c      = cmd_q.quad && (state_q != CMD);
        rx_next_c   = wide_c ? {rx_sh_q[3:0], dq_lvl} : {rx_sh_q[6:0], dq_lvl[0]};
        byte_done_c = wide_c ? bit_cnt_q[0] : (bit_cnt_q == 3'd7);
        bit_next_c  = wide_c ? {2'b00, ~bit_cnt_q[0]} : bit_cnt_q + 3'd1;
        tx_src_c    = tx_vld ? tx_dat : UNDERRUN_DAT;

        if (csn_rise_c) begin
            // Deselect aborts from any state; partial bytes are dropped.
            state_d = IDLE;
            busy_d  = 1'b0;
            dq_en_d = '0;
            dq_o_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (csn_fall_c) begin
                        state_d   = CMD;
                        busy_d    = 1'b1;
                        bit_cnt_d = '0;
                    end
                end
                CMD: begin
                    if (sck_rise_c) begin
                        rx_sh_d   = rx_next_c;
                        bit_cnt_d = bit_next_c;
                        if (byte_done_c) begin
                            cmd_d      = decode_cmd(rx_next_c);
                            cmd_vld_d  = 1'b1;
                            underrun_d = 1'b0;
                            dum_cnt_d  = '0;
                            if (!cmd_d.read) begin
                                state_d = WDATA;
                            end else if (cmd_d.quad && (DUMMY_CYC != 0)) begin
                                state_d = DUMMY;
                            end else begin
                                state_d = RDATA;
                                dq_en_d = cmd_d.quad ? 4'b1111 : 4'b0010;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (sck_rise_c) begin
                        rx_sh_d   = rx_next_c;
                        bit_cnt_d = bit_next_c;
                        if (byte_done_c) begin
                            rx_dat_d = rx_next_c;
                            rx_vld_d = 1'b1;
                        end
                    end
                end
                DUMMY: begin
                    if (sck_rise_c) begin
                        if (dum_cnt_q == 4'(DUMMY_CYC - 1)) begin
                            state_d = RDATA;
                            dq_en_d = 4'b1111;
                        end else begin
                            dum_cnt_d = dum_cnt_q + 4'd1;
                        end
                    end
                end
                RDATA: begin
                    // The first fall in RDATA and every fall after a completed byte load a new byte.
                    if (sck_fall_c) begin
                        bit_cnt_d = bit_next_c;
                        if (bit_cnt_q == 3'd0) begin
                            tx_rdy_d   = tx_vld;
                            underrun_d = underrun_q | ~tx_vld;
                            dq_o_d     = wide_c ? tx_src_c[7:4] : {2'b00, tx_src_c[7], 1'b0};
                            tx_sh_d    = wide_c ? {tx_src_c[3:0], 4'b0000} : {tx_src_c[6:0], 1'b0};
                        end else begin
                            dq_o_d  = wide_c ? tx_sh_q[7:4] : {2'b00, tx_sh_q[7], 1'b0};
                            tx_sh_d = wide_c ? (tx_sh_q << 4) : (tx_sh_q << 1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cmd_vld  = cmd_vld_q;
    assign cmd_read = cmd_q.read;
    assign cmd_quad = cmd_q.quad;
    assign cmd_addr = cmd_q.addr;
    assign rx_vld   = rx_vld_q;
    assign rx_dat   = rx_dat_q;
    assign tx_rdy   = tx_rdy_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

    assign bus.qspi_dq0_o  = dq_o_q[0];
    assign bus.qspi_dq1_o  = dq_o_q[1];
    assign bus.qspi_dq2_o  = dq_o_q[2];
    assign bus.qspi_dq3_o  = dq_o_q[3];
    assign bus.qspi_dq0_en = dq_en_q[0];
    assign bus.qspi_dq1_en = dq_en_q[1];
    assign bus.qspi_dq2_en = dq_en_q[2];
    assign bus.qspi_dq3_en = dq_en_q[3];

endmodule

// File: tb/tb_qspi_slave.sv
// tb_qspi_slave: directed mode-0 QSPI master driving qspi_slave, with a scoreboard
// that matches cmd_vld / rx_vld / tx_rdy strobes against expected events in order.
module tb_qspi_slave;

    localparam int unsigned H = 5;  // sck half-period in clk cycles
`ifdef QSPI_SLV_SYNC_EN
    localparam int unsigned LAT = 3;  // csn pad change to registered response
`else
    localparam int unsigned LAT = 2;
`endif

    localparam logic [1:0] EV_CMD = 2'd0;
    localparam logic [1:0] EV_RX  = 2'd1;
    localparam logic [1:0] EV_TX  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] dat;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck, csn;
    logic [3:0] pad_i, pad_o, pad_en;
    logic       cmd_vld, cmd_read, cmd_quad;
    logic [5:0] cmd_addr;
    logic       rx_vld;
    logic [7:0] rx_dat;
    logic       tx_vld, tx_rdy;
    logic [7:0] tx_dat;
    logic       busy, underrun;
    logic [3:0] smp_o, smp_en;

    int   checks   = 0;
    int   failures = 0;
    ev_t  exp_q[$];

    qspi_slave_if qif ();

    assign qif.qspi_sck   = sck;
    assign qif.qspi_csn   = csn;
    assign qif.qspi_dq0_i = pad_i[0];
    assign qif.qspi_dq1_i = pad_i[1];
    assign qif.qspi_dq2_i = pad_i[2];
    assign qif.qspi_dq3_i = pad_i[3];
    assign pad_o  = {qif.qspi_dq3_o, qif.qspi_dq2_o, qif.qspi_dq1_o, qif.qspi_dq0_o};
    assign pad_en = {qif.qspi_dq3_en, qif.qspi_dq2_en, qif.qspi_dq1_en, qif.qspi_dq0_en};

    qspi_slave #(.DUMMY_CYC(4), .UNDERRUN_DAT(8'hFF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (qif.slave),
        .cmd_vld  (cmd_vld),
        .cmd_read (cmd_read),
        .cmd_quad (cmd_quad),
        .cmd_addr (cmd_addr),
        .rx_vld   (rx_vld),
        .rx_dat   (rx_dat),
        .tx_vld   (tx_vld),
        .tx_rdy   (tx_rdy),
        .tx_dat   (tx_dat),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input logic [1:0] kind, input logic [7:0] dat, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected strobe actual=0x%0h required=none", name, dat);
        end else begin
            e = exp_q.pop_front();
            chk(name, {22'd0, kind, dat}, {22'd0, e.kind, e.dat});
        end
    endtask

    // Monitor: every DUT strobe must match the next expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_vld) sb_pop(EV_CMD, {cmd_read, cmd_quad, cmd_addr}, "sb_cmd");
            if (rx_vld)  sb_pop(EV_RX, rx_dat, "sb_rx");
            if (tx_rdy)  sb_pop(EV_TX, 8'h00, "sb_tx");
        end
    end

    // One sck period: data set while low, master samples the target at the rise.
    task automatic sck_cyc(input logic [3:0] d);
        pad_i = d;
        tick(H);
        sck    = 1'b1;
        smp_o  = pad_o;
        smp_en = pad_en;
        tick(H);
        sck = 1'b0;
    endtask

    task automatic start_xfer();
        csn = 1'b0;
        tick(H);
    endtask

    task automatic stop_xfer();
        tick(H);
        csn = 1'b1;
        tick(H);
    endtask

    task automatic send_cmd(input logic [7:0] c, input int unsigned n_tx);
        exp_q.push_back(ev_t'{kind: EV_CMD, dat: c});
        repeat (n_tx) exp_q.push_back(ev_t'{kind: EV_TX, dat: 8'h00});
        for (int i = 7; i >= 0; i--) sck_cyc({3'b000, c[i]});
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic quad, output logic [3:0] en_acc);
        logic [7:0] s;
        exp_q.push_back(ev_t'{kind: EV_RX, dat: b});
        s      = b;
        en_acc = '0;
        repeat (quad ? 2 : 8) begin
            sck_cyc(quad ? s[7:4] : {3'b000, s[7]});
            en_acc |= smp_en;
            s = quad ? (s << 4) : (s << 1);
        end
    endtask

    task automatic rd_byte(input logic quad, input logic [3:0] en_exp,
                           output logic [7:0] b, output logic en_ok);
        b     = '0;
        en_ok = 1'b1;
        repeat (quad ? 2 : 8) begin
            sck_cyc(4'h0);
            b     = quad ? {b[3:0], smp_o} : {b[6:0], smp_o[1]};
            en_ok = en_ok & (smp_en == en_exp);
        end
    endtask

    task automatic dummy(input int unsigned n, output logic [3:0] en_acc);
        en_acc = '0;
        repeat (n) begin
            sck_cyc(4'h0);
            en_acc |= smp_en;
        end
    endtask

    // Raise csn and check the release happens exactly one cycle after detection.
    task automatic abort_chk(input string tag, input logic [3:0] en_before);
        tick(H);
        csn = 1'b1;
        tick(LAT - 1);
        chk({tag, "_hold"}, {27'd0, busy, pad_en}, {27'd0, 1'b1, en_before});
        tick(1);
        chk({tag, "_release"}, {27'd0, busy, pad_en}, 32'd0);
        tick(H);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] en_a, en_b;
        logic [7:0] b;
        logic       ok;

        rst_n  = 1'b0;
        sck    = 1'b0;
        csn    = 1'b1;
        pad_i  = '0;
        tx_vld = 1'b0;
        tx_dat = '0;
        smp_o  = '0;
        smp_en = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("reset", {3'd0, busy, underrun, cmd_vld, rx_vld, tx_rdy, cmd_read, cmd_quad,
                      cmd_addr, rx_dat, pad_o, pad_en}, 32'd0);

        // Single write: cmd 05, byte A5.
        start_xfer();
        send_cmd(8'h05, 0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wr_byte(8'hA5, 1'b0, en_a);
        stop_xfer();
        chk("t1_en", {28'd0, en_a}, 32'd0);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        chk("t1_cmd_hold", {24'd0, cmd_read, cmd_quad, cmd_addr}, 32'h05);

        // Quad write: cmd 41, bytes 3C and 5A.
        start_xfer();
        send_cmd(8'h41, 0);
        wr_byte(8'h3C, 1'b1, en_a);
        wr_byte(8'h5A, 1'b1, en_b);
        stop_xfer();
        chk("t2_en", {28'd0, en_a | en_b}, 32'd0);

        // Single read of 96; the trailing sck fall starts a second byte, hence two tx_rdy.
        tx_vld = 1'b1;
        tx_dat = 8'h96;
        start_xfer();
        send_cmd(8'h82, 2);
        rd_byte(1'b0, 4'b0010, b, ok);
        stop_xfer();
        chk("t3_data", {24'd0, b}, 32'h96);
        chk("t3_en", {31'd0, ok}, 32'd1);
        chk("t3_underrun", {31'd0, underrun}, 32'd0);

        // Quad read with 4 dummy cycles.
        start_xfer();
        send_cmd(8'hC0, 2);
        dummy(4, en_a);
        rd_byte(1'b1, 4'b1111, b, ok);
        stop_xfer();
        chk("t4_dummy_en", {28'd0, en_a}, 32'd0);
        chk("t4_data", {24'd0, b}, 32'h96);
        chk("t4_en", {31'd0, ok}, 32'd1);

        // Underrun: quad read with nothing offered.
        tx_vld = 1'b0;
        start_xfer();
        send_cmd(8'hC0, 0);
        dummy(4, en_a);
        rd_byte(1'b1, 4'b1111, b, ok);
        stop_xfer();
        chk("t5_data", {24'd0, b}, 32'hFF);
        chk("t5_underrun", {31'd0, underrun}, 32'd1);
        chk("t5_en", {31'd0, ok}, 32'd1);

        // Write aborted after 3 data bits; the new command clears underrun.
        tx_vld = 1'b1;
        start_xfer();
        send_cmd(8'h05, 0);
        chk("t6_underrun_clr", {31'd0, underrun}, 32'd0);
        sck_cyc(4'h1);
        sck_cyc(4'h0);
        sck_cyc(4'h1);
        abort_chk("t6_wr_abort", 4'b0000);

        // Read aborted after 3 data bits: only the first byte load is consumed.
        start_xfer();
        send_cmd(8'h82, 1);
        repeat (3) sck_cyc(4'h0);
        abort_chk("t6_rd_abort", 4'b0010);

        // Normal transfer after the aborts.
        start_xfer();
        send_cmd(8'h3F, 0);
        wr_byte(8'h81, 1'b0, en_a);
        stop_xfer();
        chk("t7_en", {28'd0, en_a}, 32'd0);

        tick(20);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
